// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready requesters.
// Define FIFO_ARB_BURST_EN to hold a grant for up to MAX_BURST consecutive beats.
module fifo_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic                          fifo_write_enable,
  input  logic                          fifo_full
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("fifo_write_arbiter: NUM_REQ must be 2..16");
  end
  if (MAX_BURST < 1 || MAX_BURST > 256) begin : g_bad_max_burst
    $error("fifo_write_arbiter: MAX_BURST must be 1..256");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   last_q, last_d;

  logic               busy, vld_g, beat, last_beat, release_now;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W:0]     cand;

  // Round-robin search from last_q+1, wrapping; last_q itself is checked last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!win_found && req_valid[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Ready and write gating are purely combinational on grant and full.
  always_comb begin
    busy         = (state_q == BUSY);
    vld_g        = |(req_valid & grant_q);
    req_ready    = '0;
    fifo_data_in = '0;
    if (busy && !fifo_full) req_ready = grant_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) fifo_data_in = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
    fifo_write_enable = busy && vld_g && !fifo_full;
  end

  assign grant       = grant_q;
  assign beat        = fifo_write_enable;
  assign release_now = busy && (!vld_g || (beat && last_beat));

`ifdef FIFO_ARB_BURST_EN
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  assign last_beat = (beat_cnt_q == CNT_W'(MAX_BURST - 1));

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (release_now)  beat_cnt_d = '0;
    else if (beat)    beat_cnt_d = beat_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) beat_cnt_q <= '0;
    else     beat_cnt_q <= beat_cnt_d;
  end
`else
  assign last_beat = 1'b1;
`endif

  // Release re-arbitrates in the same edge so back-to-back grants have no bubble.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    if (!busy || release_now) begin
      if (win_found) begin
        state_d = BUSY;
        grant_d = NUM_REQ'(1) << win_idx;
        last_d  = win_idx;
      end else begin
        state_d = IDLE;
        grant_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed grant/stall/release/reset scenarios plus a
// randomized scoreboard run against a depth-8 FIFO occupancy model.
module tb_fifo_write_arbiter;
`ifdef FIFO_ARB_BURST_EN
  localparam int BURST = 4;
`else
  localparam int BURST = 1;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       req_valid = '0;
  logic [3:0][31:0] rdata = '0;
  logic [127:0]     req_data;
  logic [3:0]       req_ready, grant;
  logic [31:0]      fifo_data_in;
  logic             fifo_write_enable;
  logic             fifo_full = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [3:0]  g;
    logic        we;
    logic        full;
    logic [31:0] d;
  } exp_t;

  logic [31:0] sb_q[4][$];

  assign req_data = rdata;

  always #5 clk = ~clk;

  fifo_write_arbiter #(.DATA_WIDTH(32), .NUM_REQ(4), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .grant(grant), .fifo_data_in(fifo_data_in),
    .fifo_write_enable(fifo_write_enable), .fifo_full(fifo_full)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; fifo_full = 1'b0; rdata = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    req_valid = 4'hF;
    rdata[0] = 32'h1234_5678;
    #1;
    n_chk++; if (grant !== 4'h0) begin n_fail++; $display("FAIL reset_grant: got %h want 0", grant); end
    n_chk++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL reset_ready: got %h want 0", req_ready); end
    n_chk++; if (fifo_write_enable !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", fifo_write_enable); end
    n_chk++; if (fifo_data_in !== 32'h0) begin n_fail++; $display("FAIL reset_din: got %h want 0", fifo_data_in); end
  endtask

  task automatic test_rotation();
    int exp_q[$];
    int idx;
    do_reset();
    for (int i = 0; i < 4; i++) rdata[i] = 32'hD000_0000 | 32'(i);
    req_valid = 4'hF;
    #1;
    n_chk++; if (grant !== 4'h0) begin n_fail++; $display("FAIL rot_latency: got %h want 0", grant); end
    for (int c = 0; c <= 4*BURST; c++) exp_q.push_back((c / BURST) % 4);
    while (exp_q.size() > 0) begin
      @(negedge clk); #1;
      idx = exp_q.pop_front();
      n_chk++; if (grant !== 4'(4'b0001 << idx)) begin n_fail++; $display("FAIL rot_grant: got %h want %h", grant, 4'(4'b0001 << idx)); end
      n_chk++; if (fifo_write_enable !== 1'b1) begin n_fail++; $display("FAIL rot_we: got %b want 1", fifo_write_enable); end
      n_chk++; if (fifo_data_in !== (32'hD000_0000 | 32'(idx))) begin n_fail++; $display("FAIL rot_din: got %h want %h", fifo_data_in, 32'hD000_0000 | 32'(idx)); end
    end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk); #1;
    n_chk++; if (grant !== 4'h0) begin n_fail++; $display("FAIL rot_idle: got %h want 0", grant); end
  endtask

  task automatic test_full_stall();
    exp_t       exp_q[$];
    exp_t       e;
    int         ss, n2, n3;
    logic [3:0] acc;
    do_reset();
    ss = (BURST > 1) ? 1 : 0;
    n2 = 0; n3 = 0; acc = '0;
    for (int c = 0; c <= BURST + 3; c++) begin
      if (c < ss)             exp_q.push_back({4'b0100, 1'b1, 1'b0, 32'hA5A5_0000 + 32'(c)});
      else if (c < ss + 3)    exp_q.push_back({4'b0100, 1'b0, 1'b1, 32'hA5A5_0000 + 32'(ss)});
      else if (c < BURST + 3) exp_q.push_back({4'b0100, 1'b1, 1'b0, 32'hA5A5_0000 + 32'(c - 3)});
      else                    exp_q.push_back({4'b1000, 1'b1, 1'b0, 32'hB0B0_0000});
    end
    req_valid = 4'b1100;
    rdata[2] = 32'hA5A5_0000; rdata[3] = 32'hB0B0_0000;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      if (acc[2]) n2++;
      if (acc[3]) n3++;
      rdata[2] = 32'hA5A5_0000 + 32'(n2);
      rdata[3] = 32'hB0B0_0000 + 32'(n3);
      e = exp_q.pop_front();
      fifo_full = e.full;
      #1;
      n_chk++; if (grant !== e.g) begin n_fail++; $display("FAIL stall_grant: got %h want %h", grant, e.g); end
      n_chk++; if (req_ready !== (e.full ? 4'h0 : e.g)) begin n_fail++; $display("FAIL stall_ready: got %h want %h", req_ready, e.full ? 4'h0 : e.g); end
      n_chk++; if (fifo_write_enable !== e.we) begin n_fail++; $display("FAIL stall_we: got %b want %b", fifo_write_enable, e.we); end
      n_chk++; if (fifo_data_in !== e.d) begin n_fail++; $display("FAIL stall_din: got %h want %h", fifo_data_in, e.d); end
      acc = req_valid & req_ready;
    end
    fifo_full = 1'b0;
  endtask

  task automatic test_early_release();
    exp_t       exp_q[$];
    exp_t       e;
    int         b1;
    logic [3:0] acc;
    do_reset();
    b1 = 0; acc = '0;
    if (BURST >= 3) begin
      exp_q.push_back({4'b0010, 1'b1, 1'b0, 32'h0}); exp_q.push_back({4'b0010, 1'b1, 1'b0, 32'h0});
      exp_q.push_back({4'b0010, 1'b0, 1'b0, 32'h0}); exp_q.push_back({4'b1000, 1'b1, 1'b0, 32'h0});
    end else if (BURST == 2) begin
      exp_q.push_back({4'b0010, 1'b1, 1'b0, 32'h0}); exp_q.push_back({4'b0010, 1'b1, 1'b0, 32'h0});
      exp_q.push_back({4'b1000, 1'b1, 1'b0, 32'h0}); exp_q.push_back({4'b1000, 1'b1, 1'b0, 32'h0});
    end else begin
      exp_q.push_back({4'b0010, 1'b1, 1'b0, 32'h0}); exp_q.push_back({4'b1000, 1'b1, 1'b0, 32'h0});
      exp_q.push_back({4'b0010, 1'b1, 1'b0, 32'h0}); exp_q.push_back({4'b1000, 1'b1, 1'b0, 32'h0});
    end
    req_valid = 4'b1010;
    rdata[1] = 32'h1111_0000; rdata[3] = 32'h3333_0000;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      if (acc[1]) b1++;
      req_valid = {1'b1, 1'b0, (b1 < 2), 1'b0};
      e = exp_q.pop_front();
      #1;
      n_chk++; if (grant !== e.g) begin n_fail++; $display("FAIL early_grant: got %h want %h", grant, e.g); end
      n_chk++; if (fifo_write_enable !== e.we) begin n_fail++; $display("FAIL early_we: got %b want %b", fifo_write_enable, e.we); end
      acc = req_valid & req_ready;
    end
  endtask

  task automatic test_single_regrant();
    int         n0;
    logic [3:0] acc;
    do_reset();
    n0 = 0; acc = '0;
    req_valid = 4'b0001;
    rdata[0] = 32'hC0C0_0000;
    for (int c = 0; c < 3*BURST; c++) begin
      @(negedge clk);
      if (acc[0]) n0++;
      rdata[0] = 32'hC0C0_0000 + 32'(n0);
      #1;
      n_chk++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %h want 1", grant); end
      n_chk++; if (fifo_write_enable !== 1'b1) begin n_fail++; $display("FAIL single_we: got %b want 1", fifo_write_enable); end
      n_chk++; if (fifo_data_in !== 32'hC0C0_0000 + 32'(c)) begin n_fail++; $display("FAIL single_din: got %h want %h", fifo_data_in, 32'hC0C0_0000 + 32'(c)); end
      acc = req_valid & req_ready;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 4; i++) rdata[i] = 32'hE000_0000 | 32'(i);
    req_valid = 4'hF;
    for (int c = 0; c <= BURST; c++) @(negedge clk);
    #1;
    n_chk++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL arst_pre_grant: got %h want 2", grant); end
    #1 rst = 1'b1;
    #1;
    n_chk++; if (grant !== 4'h0) begin n_fail++; $display("FAIL arst_grant: got %h want 0", grant); end
    n_chk++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL arst_ready: got %h want 0", req_ready); end
    n_chk++; if (fifo_write_enable !== 1'b0) begin n_fail++; $display("FAIL arst_we: got %b want 0", fifo_write_enable); end
    n_chk++; if (fifo_data_in !== 32'h0) begin n_fail++; $display("FAIL arst_din: got %h want 0", fifo_data_in); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_chk++; if (grant !== 4'h0) begin n_fail++; $display("FAIL arst_release_grant: got %h want 0", grant); end
    @(negedge clk); #1;
    n_chk++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL arst_priority: got %h want 1", grant); end
  endtask

  task automatic test_scoreboard();
    int          occ, id;
    int          seq[4];
    logic        rd, we_prev;
    logic [3:0]  acc;
    logic [31:0] want;
    do_reset();
    occ = 0; rd = 1'b0; we_prev = 1'b0; acc = '0;
    for (int i = 0; i < 4; i++) begin seq[i] = 0; sb_q[i].delete(); end
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      occ = occ + (we_prev ? 1 : 0) - (rd ? 1 : 0);
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(99) < 60) begin
          rdata[i] = {4'(i), 28'(seq[i])};
          seq[i]++;
          sb_q[i].push_back(rdata[i]);
          req_valid[i] = 1'b1;
        end
      end
      fifo_full = (occ >= 8);
      rd = (occ > 0) && ($urandom_range(99) < (((c / 500) % 2 == 1) ? 35 : 85));
      #1;
      acc = req_valid & req_ready;
      we_prev = fifo_write_enable;
      n_chk++; if ((fifo_write_enable && fifo_full) !== 1'b0) begin n_fail++; $display("FAIL sb_write_full: we=%b full=%b", fifo_write_enable, fifo_full); end
      n_chk++; if (fifo_write_enable !== (|acc)) begin n_fail++; $display("FAIL sb_we_vs_handshake: got %b want %b", fifo_write_enable, |acc); end
      if (fifo_write_enable) begin
        id = int'(fifo_data_in[31:28]);
        n_chk++;
        if (id > 3 || sb_q[id % 4].size() == 0 || id != int'(fifo_data_in[31:28])) begin
          n_fail++; $display("FAIL sb_unexpected_word: got %h want a pending word", fifo_data_in);
        end else begin
          want = sb_q[id].pop_front();
          n_chk++; if (fifo_data_in !== want) begin n_fail++; $display("FAIL sb_order: got %h want %h", fifo_data_in, want); end
          n_chk++; if (grant !== 4'(4'b0001 << id)) begin n_fail++; $display("FAIL sb_grant: got %h want %h", grant, 4'(4'b0001 << id)); end
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (sb_q[i].size() != ((req_valid[i] && !acc[i]) ? 1 : 0)) begin
        n_fail++; $display("FAIL sb_drain%0d: got %0d pending want %0d", i, sb_q[i].size(), (req_valid[i] && !acc[i]) ? 1 : 0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_rotation();
    test_full_stall();
    test_early_release();
    test_single_regrant();
    test_async_reset();
    test_scoreboard();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
